// File: rtl/wb_sram_bridge.sv
// +-----------------------------------------------------------------------------+
// | Module   : wb_sram_bridge                                                    |
// | Brief    : Wishbone classic slave in front of a single-port SRAM macro.      |
// |            Registered outputs, single-cycle ack, configurable read latency. |
// |            Optional macro SRAM_BRIDGE_ERR_EN adds wbs_err_o for misses.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module wb_sram_bridge #(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FC00,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0
`ifdef SRAM_BRIDGE_ERR_EN
  ,
  output logic              wbs_err_o
`endif
);

  localparam int unsigned c_cnt_w = 3;

  // S_MISS delays a miss response so it lands in the same cycle as a write ack
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_RD_WAIT = 3'd2,
    S_MISS    = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ack, w_ack_nxt;
  logic [31:0]         r_dat, w_dat_nxt;
  logic                r_csb, w_csb_nxt;
  logic                r_web, w_web_nxt;
  logic [3:0]          r_wmask, w_wmask_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_din, w_din_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
`ifdef SRAM_BRIDGE_ERR_EN
  logic                r_err, w_err_nxt;
`endif

  logic w_req;
  logic w_hit;

  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_dat   <= 32'h0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      r_addr  <= '0;
      r_din   <= 32'h0;
      r_cnt   <= '0;
`ifdef SRAM_BRIDGE_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_dat   <= w_dat_nxt;
      r_csb   <= w_csb_nxt;
      r_web   <= w_web_nxt;
      r_wmask <= w_wmask_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef SRAM_BRIDGE_ERR_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = r_dat;
    w_csb_nxt   = 1'b1;
    w_web_nxt   = 1'b1;
    w_wmask_nxt = 4'h0;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_cnt_nxt   = r_cnt;
`ifdef SRAM_BRIDGE_ERR_EN
    w_err_nxt   = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_csb_nxt   = 1'b0;
            w_web_nxt   = ~wbs_we_i;
            w_wmask_nxt = wbs_we_i ? wbs_sel_i : 4'h0;
            w_addr_nxt  = wbs_adr_i[ADDR_W+1:2];
            w_din_nxt   = wbs_dat_i;
            w_state_nxt = S_CMD;
          end else begin
            w_dat_nxt   = 32'h0;
            w_state_nxt = S_MISS;
          end
        end
      end
      // r_web still reflects the command the macro is sampling this cycle
      S_CMD: begin
        if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (!r_web) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt   = c_cnt_w'(READ_LATENCY);
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_cnt_w'(1)) begin
          w_dat_nxt   = sram_dout0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_MISS: begin
        if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else begin
`ifdef SRAM_BRIDGE_ERR_EN
          w_err_nxt   = 1'b1;
`else
          w_ack_nxt   = 1'b1;
`endif
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
`ifdef SRAM_BRIDGE_ERR_EN
  assign wbs_err_o   = r_err;
`endif

endmodule

`default_nettype wire
